// File: rtl/des_round_ctrl.sv
// Control sequencer for the iterative DES core.
// Walks each accepted block through LOAD, NUM_ROUNDS round cycles and a result
// handshake. Every output is decoded from registered state, so there is no
// combinational path from any input to any output.
module des_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 16,
    parameter int unsigned ROUND_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               decrypt,
    input  logic               abort,
    output logic               load_init,
    output logic               key_load,
    output logic               round_en,
    output logic [ROUND_W-1:0] round_idx,
    output logic [1:0]         key_shift,
    output logic               key_dir,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    typedef enum logic [1:0] {StIdle, StLoad, StRound, StOut} state_e;

    localparam logic [ROUND_W-1:0] IdxLast = ROUND_W'(NUM_ROUNDS - 1);
    localparam logic [ROUND_W-1:0] Idx1    = ROUND_W'(1);
    localparam logic [ROUND_W-1:0] Idx8    = ROUND_W'(8);
    localparam logic [ROUND_W-1:0] Idx15   = ROUND_W'(15);

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] idx_q, idx_d;
    logic               mode_q, mode_d;

    // State, round counter and latched mode registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic; abort takes priority over both acceptance and progress.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && !abort) begin
                    mode_d  = decrypt;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                idx_d   = '0;
                state_d = abort ? StIdle : StRound;
            end
            StRound: begin
                if (abort) begin
                    idx_d   = '0;
                    state_d = StIdle;
                end else if (idx_q == IdxLast) begin
                    idx_d   = '0;
                    state_d = StOut;
                end else begin
                    idx_d = idx_q + Idx1;
                end
            end
            StOut: begin
                if (abort || out_ready) begin
                    idx_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from registered state, counter and mode.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        load_init = 1'b0;
        key_load  = 1'b0;
        round_en  = 1'b0;
        round_idx = '0;
        key_shift = 2'd0;
        key_dir   = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            StLoad: begin
                load_init = 1'b1;
                key_load  = 1'b1;
            end
            StRound: begin
                round_en  = 1'b1;
                round_idx = idx_q;
                key_dir   = mode_q;
                // Decrypt starts from the loaded key unrotated; otherwise the
                // standard 1/2-bit DES rotation table applies.
                if (idx_q == '0) begin
                    key_shift = mode_q ? 2'd0 : 2'd1;
                end else if (idx_q == Idx1 || idx_q == Idx8 || idx_q == Idx15) begin
                    key_shift = 2'd1;
                end else begin
                    key_shift = 2'd2;
                end
            end
            StOut: begin
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Randomized bench for des_round_ctrl against a block-age reference model.
module tb_des_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       decrypt = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, load_init, key_load, round_en, key_dir, out_valid, busy;
    logic [3:0] round_idx;
    logic [1:0] key_shift;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a block is described only by how many cycles it has been
    // in flight (1 = load, 2..17 = rounds 0..15, 18 = result waiting).
    bit m_busy = 1'b0;
    int m_age = 0;
    bit m_mode = 1'b0;

    des_round_ctrl #(.NUM_ROUNDS(16), .ROUND_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .decrypt   (decrypt),
        .abort     (abort),
        .load_init (load_init),
        .key_load  (key_load),
        .round_en  (round_en),
        .round_idx (round_idx),
        .key_shift (key_shift),
        .key_dir   (key_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int ref_shift(input bit dec, input int r);
        if (dec && r == 0) return 0;
        if (r == 0 || r == 1 || r == 8 || r == 15) return 1;
        return 2;
    endfunction

    task automatic check_outputs();
        bit e_load, e_round, e_out;
        int e_idx;
        e_load  = m_busy && m_age == 1;
        e_round = m_busy && m_age >= 2 && m_age <= 17;
        e_out   = m_busy && m_age == 18;
        e_idx   = e_round ? m_age - 2 : 0;
        check_eq("in_ready", int'(in_ready), int'(!m_busy));
        check_eq("busy", int'(busy), int'(m_busy));
        check_eq("load_init", int'(load_init), int'(e_load));
        check_eq("key_load", int'(key_load), int'(e_load));
        check_eq("round_en", int'(round_en), int'(e_round));
        check_eq("round_idx", int'(round_idx), e_idx);
        check_eq("key_shift", int'(key_shift), e_round ? ref_shift(m_mode, e_idx) : 0);
        check_eq("key_dir", int'(key_dir), int'(e_round && m_mode));
        check_eq("out_valid", int'(out_valid), int'(e_out));
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_age  = 0;
        m_mode = 1'b0;
    endtask

    // One clock: update the model with the inputs seen at the rising edge, then
    // compare on the following falling edge.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (in_valid && !abort) begin
                m_busy = 1'b1;
                m_age  = 1;
                m_mode = decrypt;
            end
        end else if (abort) begin
            model_reset_block();
        end else if (m_age == 18) begin
            if (out_ready) model_reset_block();
        end else begin
            m_age++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic model_reset_block();
        m_busy = 1'b0;
        m_age  = 0;
    endtask

    // Run idle-input cycles until the model block reaches the given age.
    task automatic wait_age(input int target);
        for (int i = 0; i < 40; i++) begin
            if (m_busy && m_age == target) return;
            step();
        end
        check_eq("wait_timeout", 0, 1);
    endtask

    task automatic start_block(input bit dec);
        in_valid = 1'b1;
        decrypt  = dec;
        abort    = 1'b0;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int prof;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;
        step();

        // Async reset in the middle of round 7.
        start_block(1'b0);
        wait_age(9);
        check_eq("pre_reset_idx", int'(round_idx), 7);
        #2 rst = 1'b0;
        #1 model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        step();

        // Abort coincident with a request in idle: request must not be taken.
        in_valid = 1'b1;
        abort    = 1'b1;
        step();
        in_valid = 1'b0;
        abort    = 1'b0;
        step();

        // Abort at round 5 of a decrypt block.
        start_block(1'b1);
        wait_age(7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (20) step();

        // Full blocks with 5 cycles of backpressure on the result.
        for (int d = 0; d < 2; d++) begin
            out_ready = 1'b0;
            start_block(d[0]);
            wait_age(18);
            repeat (5) step();
            out_ready = 1'b1;
            step();
            step();
        end

        // Random traffic in several profiles.
        for (int seg = 0; seg < 8; seg++) begin
            prof = $urandom_range(0, 3);
            for (int c = 0; c < 500; c++) begin
                decrypt = 1'($urandom_range(0, 1));
                unique case (prof)
                    0: begin
                        in_valid  = 1'($urandom_range(0, 1));
                        out_ready = 1'($urandom_range(0, 1));
                        abort     = ($urandom_range(0, 39) == 0);
                    end
                    1: begin
                        in_valid  = 1'b1;
                        out_ready = 1'b1;
                        abort     = 1'b0;
                    end
                    2: begin
                        in_valid  = ($urandom_range(0, 3) != 0);
                        out_ready = ($urandom_range(0, 5) == 0);
                        abort     = 1'b0;
                    end
                    default: begin
                        in_valid  = 1'($urandom_range(0, 1));
                        out_ready = 1'($urandom_range(0, 1));
                        abort     = ($urandom_range(0, 7) == 0);
                    end
                endcase
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
